// File: rtl/display_arbiter_if.sv
// Port bundle for display_arbiter: live A digits, the B message request/grant handshake,
// and the registered digit/blank outputs that feed the digit rotator.
interface display_arbiter_if;
  logic [15:0] a_digits;
  logic        b_req;
  logic [15:0] b_digits;
  logic        b_blink;
  logic        b_ack;
  logic        b_done;
  logic        busy;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic [3:0]  blank;

  modport master (
    output a_digits, b_req, b_digits, b_blink,
    input  b_ack, b_done, busy, digit0, digit1, digit2, digit3, blank
  );

  modport slave (
    input  a_digits, b_req, b_digits, b_blink,
    output b_ack, b_done, busy, digit0, digit1, digit2, digit3, blank
  );
endinterface

// File: rtl/display_arbiter.sv
// Shares the 4-digit display: live A by default, B messages borrow it for HOLD_CYCLES.
// One-cycle registered latency; a B request is held pending until the minimum A gap has elapsed.
module display_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 25_000_000,
  parameter int BLINK_HALF  = 25_000_000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  display_arbiter_if.slave io_disp
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX    = GW'(GAP_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [0:0] SHOW_A = 1'b0;
  localparam logic [0:0] SHOW_B = 1'b1;

  logic [0:0]    r_state;
  logic [HW-1:0] r_hold;
  logic [GW-1:0] r_gap;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic          r_blink;
  logic [15:0]   r_digits;
  logic [3:0]    r_blank;
  logic          r_ack;
  logic          r_done;
  logic          r_busy;

  logic          w_gap_ok;
  logic          w_grant;
  logic          w_last;
  logic          w_phase_nxt;
  logic          w_lz3;
  logic          w_lz2;
  logic          w_lz1;
  logic [GW-1:0] w_gap_inc;
  logic [BW-1:0] w_bcnt_nxt;
  logic [3:0]    w_a_blank;

  // Leading-zero mask cascades from the most significant digit; digit 0 always shows.
  assign w_lz3     = LZ_BLANK && (io_disp.a_digits[15:12] == 4'h0);
  assign w_lz2     = w_lz3 && (io_disp.a_digits[11:8] == 4'h0);
  assign w_lz1     = w_lz2 && (io_disp.a_digits[7:4] == 4'h0);
  assign w_a_blank = {w_lz3, w_lz2, w_lz1, 1'b0};

  assign w_gap_ok    = (r_gap == GAP_MAX);
  assign w_gap_inc   = w_gap_ok ? r_gap : r_gap + GW'(1);
  assign w_grant     = (r_state == SHOW_A) && io_disp.b_req && w_gap_ok;
  assign w_last      = (r_hold == '0);
  assign w_phase_nxt = (r_bcnt == BLINK_LAST) ? ~r_phase : r_phase;
  assign w_bcnt_nxt  = (r_bcnt == BLINK_LAST) ? '0 : r_bcnt + BW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= SHOW_A;
      r_hold   <= '0;
      r_gap    <= GAP_MAX;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
      r_blink  <= 1'b0;
      r_digits <= '0;
      r_blank  <= 4'b1110;
      r_ack    <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (r_state == SHOW_A) begin
        r_gap <= w_gap_inc;
        if (w_grant) begin
          r_state  <= SHOW_B;
          r_hold   <= HOLD_LOAD;
          r_bcnt   <= '0;
          r_phase  <= 1'b0;
          r_blink  <= io_disp.b_blink;
          r_digits <= io_disp.b_digits;
          r_blank  <= 4'b0000;
          r_ack    <= 1'b1;
          r_busy   <= 1'b1;
        end else begin
          r_digits <= io_disp.a_digits;
          r_blank  <= w_a_blank;
        end
      end else begin
        r_bcnt  <= w_bcnt_nxt;
        r_phase <= w_phase_nxt;
        if (w_last) begin
          // Gap was zeroed on the final message cycle; this edge counts the first A cycle.
          r_state  <= SHOW_A;
          r_busy   <= 1'b0;
          r_gap    <= w_gap_inc;
          r_digits <= io_disp.a_digits;
          r_blank  <= w_a_blank;
        end else begin
          r_hold  <= r_hold - HW'(1);
          r_blank <= (r_blink && w_phase_nxt) ? 4'b1111 : 4'b0000;
          if (r_hold == HW'(1)) begin
            r_done <= 1'b1;
            r_gap  <= '0;
          end
        end
      end
    end
  end

  assign io_disp.digit0 = r_digits[3:0];
  assign io_disp.digit1 = r_digits[7:4];
  assign io_disp.digit2 = r_digits[11:8];
  assign io_disp.digit3 = r_digits[15:12];
  assign io_disp.blank  = r_blank;
  assign io_disp.b_ack  = r_ack;
  assign io_disp.b_done = r_done;
  assign io_disp.busy   = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: reset, leading-zero mask, message timing,
// back-to-back gap, blink, reset abort, and LZ_BLANK=0 mask.
module tb_display_arbiter;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int BH   = 2;

  localparam logic [15:0] LZ_A [5] = '{16'h0042, 16'h0000, 16'h0105, 16'h1234, 16'h0009};
  localparam logic [3:0]  LZ_B [5] = '{4'b1100,  4'b1110,  4'b1000,  4'b0000,  4'b1110};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  display_arbiter_if if_a ();
  display_arbiter_if if_n ();

  display_arbiter #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BLINK_HALF(BH), .LZ_BLANK(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .io_disp(if_a)
  );

  display_arbiter #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BLINK_HALF(BH), .LZ_BLANK(1'b0)
  ) dut_nolz (
    .i_clk(clk), .i_rst(rst), .io_disp(if_n)
  );

  logic [15:0] dig_a;
  logic [15:0] dig_n;
  assign dig_a = {if_a.digit3, if_a.digit2, if_a.digit1, if_a.digit0};
  assign dig_n = {if_n.digit3, if_n.digit2, if_n.digit1, if_n.digit0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_a.b_req = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++; if (dig_a !== 16'h0000) begin miscompares++; $display("FAIL reset_digits: got %h expected 0000", dig_a); end
    vectors++; if (if_a.blank !== 4'b1110) begin miscompares++; $display("FAIL reset_blank: got %b expected 1110", if_a.blank); end
    vectors++; if (if_a.b_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", if_a.b_ack); end
    vectors++; if (if_a.b_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", if_a.b_done); end
    vectors++; if (if_a.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", if_a.busy); end
    vectors++; if (if_n.blank !== 4'b1110) begin miscompares++; $display("FAIL reset_blank_nolz: got %b expected 1110", if_n.blank); end
    rst = 1'b0;
  endtask

  task automatic test_leading_zero();
    for (int i = 0; i < 5; i++) begin
      if_a.a_digits = LZ_A[i];
      if_n.a_digits = LZ_A[i];
      tick();
      vectors++; if (dig_a !== LZ_A[i]) begin miscompares++; $display("FAIL lz_digits[%0d]: got %h expected %h", i, dig_a, LZ_A[i]); end
      vectors++; if (if_a.blank !== LZ_B[i]) begin miscompares++; $display("FAIL lz_blank[%0d]: got %b expected %b", i, if_a.blank, LZ_B[i]); end
      vectors++; if (dig_n !== LZ_A[i]) begin miscompares++; $display("FAIL nolz_digits[%0d]: got %h expected %h", i, dig_n, LZ_A[i]); end
      vectors++; if (if_n.blank !== 4'b0000) begin miscompares++; $display("FAIL nolz_blank[%0d]: got %b expected 0000", i, if_n.blank); end
    end
  endtask

  task automatic test_message();
    logic [15:0] ed;
    logic [3:0]  eb;
    logic        ea, eo, eu;
    if_a.a_digits = 16'h0042;
    if_a.b_digits = 16'hE0F1;
    if_a.b_blink  = 1'b0;
    if_a.b_req    = 1'b1;
    for (int k = 1; k <= HOLD + 1; k++) begin
      tick();
      eu = (k <= HOLD);
      ea = (k == 1);
      eo = (k == HOLD);
      ed = eu ? 16'hE0F1 : 16'h0301;
      eb = eu ? 4'b0000 : 4'b1000;
      vectors++; if (if_a.busy !== eu) begin miscompares++; $display("FAIL msg_busy k=%0d: got %b expected %b", k, if_a.busy, eu); end
      vectors++; if (if_a.b_ack !== ea) begin miscompares++; $display("FAIL msg_ack k=%0d: got %b expected %b", k, if_a.b_ack, ea); end
      vectors++; if (if_a.b_done !== eo) begin miscompares++; $display("FAIL msg_done k=%0d: got %b expected %b", k, if_a.b_done, eo); end
      vectors++; if (dig_a !== ed) begin miscompares++; $display("FAIL msg_digits k=%0d: got %h expected %h", k, dig_a, ed); end
      vectors++; if (if_a.blank !== eb) begin miscompares++; $display("FAIL msg_blank k=%0d: got %b expected %b", k, if_a.blank, eb); end
      if (k == 1) if_a.b_req = 1'b0;
      if (k == 2) if_a.b_digits = 16'h1111;
      if (k == 3) if_a.a_digits = 16'h0301;
      if (k == 4) if_a.b_req = 1'b1;
      if (k == 5) if_a.b_req = 1'b0;
    end
    if_a.a_digits = 16'h0042;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ed;
    logic [3:0]  eb;
    logic        ea, eo, eu;
    if_a.a_digits = 16'h0042;
    if_a.b_digits = 16'hABCD;
    if_a.b_blink  = 1'b0;
    if_a.b_req    = 1'b1;
    for (int k = 1; k <= 2 * HOLD + GAP + 1; k++) begin
      tick();
      ea = (k == 1) || (k == HOLD + GAP + 1);
      eo = (k == HOLD) || (k == 2 * HOLD + GAP);
      eu = (k <= HOLD) || ((k >= HOLD + GAP + 1) && (k <= 2 * HOLD + GAP));
      ed = (k <= HOLD) ? 16'hABCD : (eu ? 16'h5678 : 16'h0042);
      eb = eu ? 4'b0000 : 4'b1100;
      vectors++; if (if_a.busy !== eu) begin miscompares++; $display("FAIL b2b_busy k=%0d: got %b expected %b", k, if_a.busy, eu); end
      vectors++; if (if_a.b_ack !== ea) begin miscompares++; $display("FAIL b2b_ack k=%0d: got %b expected %b", k, if_a.b_ack, ea); end
      vectors++; if (if_a.b_done !== eo) begin miscompares++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, if_a.b_done, eo); end
      vectors++; if (dig_a !== ed) begin miscompares++; $display("FAIL b2b_digits k=%0d: got %h expected %h", k, dig_a, ed); end
      vectors++; if (if_a.blank !== eb) begin miscompares++; $display("FAIL b2b_blank k=%0d: got %b expected %b", k, if_a.blank, eb); end
      if (k == HOLD + 2) if_a.b_digits = 16'h5678;
      if (k == HOLD + GAP + 1) if_a.b_req = 1'b0;
    end
  endtask

  task automatic test_blink();
    logic [15:0] ed;
    logic [3:0]  eb;
    logic        ea, eo;
    if_a.a_digits = 16'h0042;
    if_a.b_digits = 16'h9876;
    if_a.b_blink  = 1'b1;
    if_a.b_req    = 1'b1;
    for (int k = 1; k <= HOLD + 1; k++) begin
      tick();
      ea = (k == 1);
      eo = (k == HOLD);
      ed = (k <= HOLD) ? 16'h9876 : 16'h0042;
      if (k > HOLD) eb = 4'b1100;
      else eb = ((((k - 1) / BH) % 2) == 1) ? 4'b1111 : 4'b0000;
      vectors++; if (if_a.b_ack !== ea) begin miscompares++; $display("FAIL blink_ack k=%0d: got %b expected %b", k, if_a.b_ack, ea); end
      vectors++; if (if_a.b_done !== eo) begin miscompares++; $display("FAIL blink_done k=%0d: got %b expected %b", k, if_a.b_done, eo); end
      vectors++; if (dig_a !== ed) begin miscompares++; $display("FAIL blink_digits k=%0d: got %h expected %h", k, dig_a, ed); end
      vectors++; if (if_a.blank !== eb) begin miscompares++; $display("FAIL blink_blank k=%0d: got %b expected %b", k, if_a.blank, eb); end
      if (k == 1) begin
        if_a.b_req   = 1'b0;
        if_a.b_blink = 1'b0;
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] ed;
    logic [3:0]  eb;
    logic        ea, eo, eu;
    if_a.a_digits = 16'h0042;
    if_a.b_digits = 16'h4321;
    if_a.b_blink  = 1'b0;
    if_a.b_req    = 1'b1;
    for (int k = 1; k <= HOLD + 6; k++) begin
      tick();
      if (k <= 4) begin
        eu = 1'b1; ea = (k == 1); eo = 1'b0; ed = 16'h4321; eb = 4'b0000;
      end else if (k == 5) begin
        eu = 1'b0; ea = 1'b0; eo = 1'b0; ed = 16'h0000; eb = 4'b1110;
      end else if (k <= HOLD + 5) begin
        eu = 1'b1; ea = (k == 6); eo = (k == HOLD + 5); ed = 16'h2468; eb = 4'b0000;
      end else begin
        eu = 1'b0; ea = 1'b0; eo = 1'b0; ed = 16'h0042; eb = 4'b1100;
      end
      vectors++; if (if_a.busy !== eu) begin miscompares++; $display("FAIL abort_busy k=%0d: got %b expected %b", k, if_a.busy, eu); end
      vectors++; if (if_a.b_ack !== ea) begin miscompares++; $display("FAIL abort_ack k=%0d: got %b expected %b", k, if_a.b_ack, ea); end
      vectors++; if (if_a.b_done !== eo) begin miscompares++; $display("FAIL abort_done k=%0d: got %b expected %b", k, if_a.b_done, eo); end
      vectors++; if (dig_a !== ed) begin miscompares++; $display("FAIL abort_digits k=%0d: got %h expected %h", k, dig_a, ed); end
      vectors++; if (if_a.blank !== eb) begin miscompares++; $display("FAIL abort_blank k=%0d: got %b expected %b", k, if_a.blank, eb); end
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        if_a.b_digits = 16'h2468;
      end
      if (k == 6) if_a.b_req = 1'b0;
    end
  endtask

  initial begin
    if_a.a_digits = 16'h0000;
    if_a.b_req    = 1'b0;
    if_a.b_digits = 16'h0000;
    if_a.b_blink  = 1'b0;
    if_n.a_digits = 16'h0000;
    if_n.b_req    = 1'b0;
    if_n.b_digits = 16'h0000;
    if_n.b_blink  = 1'b0;
    test_reset();
    test_leading_zero();
    test_message();
    idle(GAP + 2);
    test_back_to_back();
    idle(GAP + 2);
    test_blink();
    idle(GAP + 2);
    test_reset_abort();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the four-digit seven-segment display between two sources: the live calculator entry/result path (source A, default owner) and a message source (source B: error codes, overflow, status) that borrows the display for a fixed hold time. The block sits directly upstream of the digit-multiplexing rotator, drives its four digit inputs from registers, and provides a per-digit blank mask. It also provides leading-zero suppression for A, optional blinking for B messages, and a guaranteed minimum A-visible gap between messages.

## Interface
- HOLD_CYCLES, 100_000_000 — cycles a B message stays on the display; must be ≥ 2.
- GAP_CYCLES, 25_000_000 — minimum cycles A is shown between two B messages; must be ≥ 1.
- BLINK_HALF, 25_000_000 — half-period of B blink, in cycles; must be ≥ 1.
- LZ_BLANK, 1 — 1 enables leading-zero blanking of A digits 3..1.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_digits  in  16  live A digits {d3,d2,d1,d0}, 4 bits each.
- b_req  in  1  level request from B; held until b_ack.
- b_digits  in  16  message digits; sampled only on the grant cycle.
- b_blink  in  1  blink enable for the message; sampled on the grant cycle.
- b_ack  out  1  one-cycle pulse: the request was granted and its data latched.
- b_done  out  1  one-cycle pulse on the last cycle the message is displayed.
- busy  out  1  high while B owns the display.
- digit0..digit3  out  4 each  registered digits to the rotator.
- blank  out  4  registered per-digit blank mask; bit i = 1 blanks digit i.

## Operation
- Two-state FSM: SHOW_A (reset state) and SHOW_B.
- Counters:
  - hold counter, width $clog2(HOLD_CYCLES).
  - gap counter, width $clog2(GAP_CYCLES+1), saturating.
  - blink counter, width $clog2(BLINK_HALF), plus a phase bit.
- gap_ok is high when the gap counter equals GAP_CYCLES.
- Reset:
  - state = SHOW_A; outputs digits = 0, blank = 4'b1110, b_ack = b_done = busy = 0.
  - Gap counter is set to GAP_CYCLES (gap satisfied), so the first request is granted immediately.
- SHOW_A:
  - Each cycle, digits ← a_digits.
  - Blank, with LZ_BLANK = 1: bit3 = (d3 == 0); bit2 = bit3 & (d2 == 0); bit1 = bit2 & (d1 == 0); bit0 = 0 always.
  - Blank, with LZ_BLANK = 0: 4'b0000.
  - The gap counter increments, saturating at GAP_CYCLES.
- SHOW_A → SHOW_B when b_req & gap_ok:
  - Latch b_digits and b_blink, pulse b_ack, load the hold counter with HOLD_CYCLES-1.
  - Clear the blink counter; phase = visible.
- SHOW_B:
  - digits = latched message.
  - blank = 4'b0000 when b_blink is latched low or phase is visible; 4'b1111 when blink is on and phase is dark.
  - Phase toggles every BLINK_HALF cycles.
  - Hold counter decrements. b_req is ignored and no further b_ack is issued.
  - Changes on a_digits/b_digits have no effect.
- SHOW_B → SHOW_A when the hold counter reaches 0:
  - b_done pulses in that same (last) cycle.
  - Gap counter clears to 0.
- busy = (state == SHOW_B), registered alongside the digits.
- Rst asserted mid-message: the message is aborted, no b_done is issued, and the reset values apply the next cycle.
- A request arriving while gap_ok is low stays pending; it is granted on the first cycle gap_ok is high.

## Timing
- Latency for A: a_digits/blank change at cycle N appears on the outputs at N+1.
- Grant: b_req high at cycle N in SHOW_A with gap_ok →
  - b_ack = 1, busy = 1, and digits = b_digits(N) at N+1.
- The message occupies exactly HOLD_CYCLES output cycles, N+1 .. N+HOLD_CYCLES.
  - b_done = 1 at N+HOLD_CYCLES.
  - At N+HOLD_CYCLES+1, busy = 0 and digits = a_digits(N+HOLD_CYCLES).
- Earliest next b_ack is at N+HOLD_CYCLES+1+GAP_CYCLES.
- Blink: with b_blink latched, the message is visible for cycles N+1 .. N+BLINK_HALF, dark for the next BLINK_HALF, and so on.
- b_ack and b_done are never high in the same cycle (guaranteed by HOLD_CYCLES ≥ 2).

## Test plan
Use HOLD_CYCLES=8, GAP_CYCLES=4, BLINK_HALF=2, LZ_BLANK=1 unless noted.
- Reset then a_digits=16'h0042 → one cycle later digits={0,0,4,2}, blank=4'b1100; with a_digits=16'h0000, blank=4'b1110.
- b_req=1 at cycle 10 with b_digits=16'hE0F1, b_blink=0 →
  - b_ack at 11; digits=E,0,F,1 for cycles 11..18; b_done at 18; A digits shown at 19.
- Back-to-back: b_req held high after the first message → second b_ack exactly at cycle 23; A is visible for cycles 19..22.
- b_blink=1 grant at cycle 10 → blank is 0000 at 11–12, 1111 at 13–14, 0000 at 15–16, 1111 at 17–18; 1100-style A mask resumes at 19.
- rst pulsed at cycle 14 during a message → no b_done; at 15 busy=0, digits=0, blank=1110; b_req still high → b_ack at 16.
- b_digits changed and b_req toggled during SHOW_B → displayed message unchanged and no extra b_ack; with LZ_BLANK=0, A blank stays 0000.
